// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: pin synchronizers and glitch filters, odd-parity
// frame decoder with idle timeout, and a byte FIFO with sticky status flags.
module ps2_rx_fifo #(
   parameter int unsigned DEPTH   = 8,
   parameter int unsigned FILTER  = 4,
   parameter int unsigned TIMEOUT = 2000
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     ps2_clk,
   input  logic                     ps2_data,
   input  logic                     rd_en,
   input  logic                     int_clear,
   output logic [7:0]               rd_data,
   output logic                     valid,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     irq,
   output logic                     parity_err,
   output logic                     frame_err,
   output logic                     overflow
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned FW = $clog2(FILTER + 1);
   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

   logic [1:0]    w_raw;
   logic [1:0]    r_s1, r_s2, r_filt;
   logic [FW-1:0] r_fcnt [2];
   logic          r_clk_fd;
   logic          w_evt, w_dat;

   assign w_raw = {ps2_data, ps2_clk};

   // Bit 0 = clock, bit 1 = data; idle-high reset avoids a false event on release.
   for (genvar g = 0; g < 2; g++) begin : g_filt
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            r_s1[g]   <= 1'b1;
            r_s2[g]   <= 1'b1;
            r_filt[g] <= 1'b1;
            r_fcnt[g] <= '0;
         end else begin
            r_s1[g] <= w_raw[g];
            r_s2[g] <= r_s1[g];
            if (r_s2[g] != r_filt[g]) begin
               if (r_fcnt[g] == FW'(FILTER - 1)) begin
                  r_filt[g] <= r_s2[g];
                  r_fcnt[g] <= '0;
               end else begin
                  r_fcnt[g] <= r_fcnt[g] + FW'(1);
               end
            end else begin
               r_fcnt[g] <= '0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) r_clk_fd <= 1'b1;
      else        r_clk_fd <= r_filt[0];
   end

   assign w_evt = r_clk_fd & ~r_filt[0];
   assign w_dat = r_filt[1];

   state_t        r_state, w_state_nxt;
   logic [2:0]    r_bit_cnt, w_bit_nxt;
   logic [7:0]    r_shift, w_shift_nxt;
   logic          r_par, w_par_nxt;
   logic [TW-1:0] r_idle, w_idle_nxt;
   logic          w_push, w_perr_set, w_ferr_set;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_par     <= 1'b0;
         r_idle    <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_bit_cnt <= w_bit_nxt;
         r_shift   <= w_shift_nxt;
         r_par     <= w_par_nxt;
         r_idle    <= w_idle_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_bit_nxt   = r_bit_cnt;
      w_shift_nxt = r_shift;
      w_par_nxt   = r_par;
      w_idle_nxt  = '0;
      w_push      = 1'b0;
      w_perr_set  = 1'b0;
      w_ferr_set  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_evt && !w_dat) begin
               w_state_nxt = S_DATA;
               w_bit_nxt   = '0;
            end
         end
         S_DATA: begin
            if (w_evt) begin
               w_shift_nxt = {w_dat, r_shift[7:1]};
               w_bit_nxt   = r_bit_cnt + 3'd1;
               if (r_bit_cnt == 3'd7) w_state_nxt = S_PARITY;
            end
         end
         S_PARITY: begin
            if (w_evt) begin
               w_par_nxt   = w_dat;
               w_state_nxt = S_STOP;
            end
         end
         S_STOP: begin
            if (w_evt) begin
               w_state_nxt = S_IDLE;
               if (!w_dat)                      w_ferr_set = 1'b1;
               else if (!(^{r_shift, r_par}))  w_perr_set = 1'b1;
               else                             w_push     = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      // Abort a frame whose clock has stalled mid-way.
      if (r_state != S_IDLE && !w_evt) begin
         if (r_idle == TW'(TIMEOUT - 1)) begin
            w_state_nxt = S_IDLE;
            w_ferr_set  = 1'b1;
         end else begin
            w_idle_nxt = r_idle + TW'(1);
         end
      end
   end

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wptr, r_rptr, w_rptr_nxt;
   logic [CW-1:0] w_count_nxt, w_remain;
   logic          w_do_pop, w_do_push, w_ovf_set, w_is_full;
   logic [7:0]    w_rd_nxt;

   assign w_is_full   = (count == CW'(DEPTH));
   assign w_do_pop    = rd_en & (count != '0);
   assign w_do_push   = w_push & (~w_is_full | w_do_pop);
   assign w_ovf_set   = w_push & w_is_full & ~w_do_pop;
   assign w_count_nxt = count + CW'(w_do_push) - CW'(w_do_pop);
   assign w_remain    = count - CW'(w_do_pop);
   assign w_rptr_nxt  = r_rptr + AW'(w_do_pop);

   // A byte pushed into an otherwise drained FIFO is forwarded straight to rd_data.
   always_comb begin
      w_rd_nxt = 8'h00;
      if (w_count_nxt != '0) begin
         if (w_remain == '0) w_rd_nxt = r_shift;
         else                w_rd_nxt = r_mem[w_rptr_nxt];
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wptr] <= r_shift;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         count      <= '0;
         empty      <= 1'b1;
         full       <= 1'b0;
         rd_data    <= 8'h00;
         valid      <= 1'b0;
         irq        <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         r_wptr     <= r_wptr + AW'(w_do_push);
         r_rptr     <= w_rptr_nxt;
         count      <= w_count_nxt;
         empty      <= (w_count_nxt == '0);
         full       <= (w_count_nxt == CW'(DEPTH));
         rd_data    <= w_rd_nxt;
         valid      <= w_do_push;
         irq        <= w_do_push  | (irq & ~int_clear);
         parity_err <= w_perr_set | (parity_err & ~int_clear);
         frame_err  <= w_ferr_set | (frame_err & ~int_clear);
         overflow   <= w_ovf_set  | (overflow & ~int_clear);
      end
   end

endmodule

// File: doc/ps2_rx_fifo.md
PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
REQ-001 Parameter DEPTH, 8, FIFO entries; power of two, >=2.
REQ-002 Parameter FILTER, 4, consecutive clk cycles an input must hold a new level before the filtered copy follows.
REQ-003 Parameter TIMEOUT, 2000, clk cycles without a filtered ps2_clk falling edge before a partial frame is aborted.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 ps2_clk  input  1  raw PS/2 clock pin, asynchronous.
REQ-007 ps2_data  input  1  raw PS/2 data pin, asynchronous.
REQ-008 rd_en  input  1  pop request, one entry per cycle while high and not empty.
REQ-009 int_clear  input  1  clears irq, parity_err, frame_err and overflow.
REQ-010 rd_data  output  8  oldest FIFO entry; 0x00 when empty.
REQ-011 valid  output  1  one-cycle pulse per byte written to the FIFO.
REQ-012 empty / full  output  1 each  FIFO status.
REQ-013 count  output  $clog2(DEPTH)+1  entries held, 0..DEPTH.
REQ-014 irq  output  1  sticky: byte received.
REQ-015 parity_err / frame_err / overflow  output  1 each  sticky error flags.

Function
REQ-016 Each pin passes a 2-flop synchronizer, then a filter: filtered level changes only after FILTER consecutive cycles at the new level.
REQ-017 A bit event is a 1->0 transition of filtered ps2_clk; filtered ps2_data is sampled in that cycle.
REQ-018 FSM states IDLE, DATA, PARITY, STOP.
REQ-019 IDLE: event with data=0 -> DATA, bit counter 0; event with data=1 ignored, stays IDLE.
REQ-020 DATA: 8 events shift data in LSB first; after the 8th -> PARITY.
REQ-021 PARITY: event captures parity bit -> STOP; odd parity over 8 data bits plus parity bit required.
REQ-022 STOP: event returns to IDLE; stop=1 and parity good -> push; parity bad -> parity_err set, no push; stop=0 -> frame_err set, no push (frame_err takes precedence when both bad).
REQ-023 Outside IDLE, an idle counter resets on every event; reaching TIMEOUT -> IDLE, frame_err set, partial byte discarded.
REQ-024 Push latency: stop-bit event in cycle E -> valid, count+1, empty=0 and irq=1 in cycle E+1.
REQ-025 Push while full without pop: byte dropped, overflow set, valid not pulsed, contents unchanged.
REQ-026 Pop: rd_en high and empty=0 -> next entry (or 0x00) on rd_data and count-1 next cycle; rd_en while empty ignored.
REQ-027 Simultaneous push and pop: both performed, count unchanged; when full, no overflow; when empty, only push.
REQ-028 Pointers wrap modulo DEPTH; full = (count==DEPTH), empty = (count==0).
REQ-029 int_clear clears sticky flags next cycle; a set event in the same cycle wins.

Reset
REQ-030 rst_n low at a clk edge: FSM IDLE, counters and pointers 0, count=0, empty=1, full=0, rd_data=0x00, valid=irq=parity_err=frame_err=overflow=0.
REQ-031 Synchronizer and filter state reset to 1 (line idle) so release of reset causes no false event.
REQ-032 Reset mid-frame discards the partial byte and FIFO contents; the next complete frame is received normally.

Verification
REQ-033 Frame 0x1C, parity 0, stop 1 -> valid pulse, rd_data=0x1C, count=1, irq=1; int_clear -> irq=0.
REQ-034 Frame 0x5A, parity 0 (bad) -> parity_err=1, count=0, no valid; frame 0x5A, stop 0 -> frame_err=1.
REQ-035 DEPTH=8: frames 0x01..0x09, no pops -> full=1, overflow=1 after 0x09; pops return 0x01..0x08 then empty=1.
REQ-036 Start bit plus 4 data bits, then TIMEOUT idle cycles -> frame_err=1, FSM IDLE; following frame 0x29 -> rd_data=0x29.
REQ-037 ps2_clk low glitches of FILTER-1 cycles inside a frame -> no extra bits; byte 0x3A received correctly.
REQ-038 count=8 with push and rd_en in the same cycle -> count stays 8, overflow=0, oldest entry removed.
